// File: rtl/reset_req_pulser.sv
// reset_req_pulser: turns asynchronous per-channel request levels into
// prioritised, fixed-length, one-hot reset pulses. A holdoff gap separates
// consecutive pulses. Requests that arrive while busy are queued, except
// repeat requests from the channel that is currently pulsing.
module reset_req_pulser #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 6,
  parameter int HOLDOFF = 16,
  parameter int RISING  = 1,
  localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_in,
  input  logic [NUM_CH*CNT_W-1:0] pulse_len,
  input  logic                    abort,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic                    busy,
  output logic [NUM_CH-1:0]       pending,
  output logic [AW-1:0]           active_ch
);

  // Synchronizers idle at the inactive level, so a request that is already
  // active when reset releases still produces exactly one edge.
  localparam logic       INACT     = (RISING != 0) ? 1'b0 : 1'b1;
  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD} state_t;

  logic [NUM_CH-1:0] r_sync1, r_sync2, r_prev, r_edge;
  logic [NUM_CH-1:0] r_pending, r_pulse_out;
  logic [AW-1:0]     r_active_ch;
  logic              r_busy;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_hcnt;

  logic [NUM_CH-1:0] w_edge, w_sel_oh, w_clr, w_ignore;
  logic [AW-1:0]     w_sel_idx;
  logic [CNT_W-1:0]  w_len_raw, w_len_load;

  // Index of the lowest set bit; channel 0 has the highest priority.
  function automatic logic [AW-1:0] f_lowest(input logic [NUM_CH-1:0] v);
    f_lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = AW'(i);
    end
  endfunction

  assign w_edge    = (RISING != 0) ? (r_sync2 & ~r_prev) : (~r_sync2 & r_prev);
  assign w_sel_oh  = r_pending & (~r_pending + NUM_CH'(1));
  assign w_sel_idx = f_lowest(r_pending);
  assign w_clr     = (r_state == S_IDLE) ? w_sel_oh : '0;
  // While pulsing, pulse_out is the one-hot mask of the active channel.
  assign w_ignore  = (r_state == S_PULSE) ? r_pulse_out : '0;

  // Pick the selected channel's length field; a zero length still gives one cycle.
  always_comb begin
    w_len_raw  = pulse_len[int'(w_sel_idx)*CNT_W +: CNT_W];
    w_len_load = (w_len_raw == '0) ? CNT_W'(1) : w_len_raw;
  end

  // Two-flop synchronizer followed by a registered edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= {NUM_CH{INACT}};
      r_sync2 <= {NUM_CH{INACT}};
      r_prev  <= {NUM_CH{INACT}};
      r_edge  <= '0;
    end else begin
      r_sync1 <= req_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= w_edge;
    end
  end

  // Pending requests: a new edge beats the clear of a just-selected channel.
  // Edges from the channel that is currently pulsing are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (abort) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | (r_edge & ~w_ignore);
    end
  end

  // Control FSM with registered pulse, busy and active-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pulse_out <= '0;
      r_busy      <= 1'b0;
      r_active_ch <= '0;
      r_cnt       <= '0;
      r_hcnt      <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_pulse_out <= '0;
      r_busy      <= 1'b0;
      r_active_ch <= '0;
      r_cnt       <= '0;
      r_hcnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_state     <= S_PULSE;
            r_pulse_out <= w_sel_oh;
            r_active_ch <= w_sel_idx;
            r_cnt       <= w_len_load;
            r_busy      <= 1'b1;
          end
        end
        S_PULSE: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_pulse_out <= '0;
            r_active_ch <= '0;
            r_cnt       <= '0;
            if (HOLDOFF == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_HOLD;
              r_hcnt  <= HOLD_INIT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_hcnt <= 8'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt - 8'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_pulse_out <= '0;
          r_busy      <= 1'b0;
          r_active_ch <= '0;
        end
      endcase
    end
  end

  assign pulse_out = r_pulse_out;
  assign busy      = r_busy;
  assign pending   = r_pending;
  assign active_ch = r_active_ch;

endmodule
